// File: rtl/caption_overlay_ctl.sv
// Caption overlay stage: walks the 1-bit caption ROM in step with the VGA stream and paints
// CAP_COLOR over the caption window. Define CAPTION_BLINK_EN to make the shown caption blink.
module caption_overlay_ctl #(
  parameter int          XPOS         = 148,
  parameter int          YPOS         = 268,
  parameter int          CAP_W        = 344,
  parameter int          CAP_H        = 64,
`ifdef CAPTION_BLINK_EN
  parameter int          BLINK_FRAMES = 30,
`endif
  parameter logic [11:0] CAP_COLOR    = 12'hF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        show,
  input  logic        hide,
  output logic [14:0] rom_address,
  input  logic        pixel_bit,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        visible
);

  localparam logic [10:0] X_LO   = 11'(XPOS);
  localparam logic [10:0] X_HI   = 11'(XPOS + CAP_W);
  localparam logic [10:0] X_LAST = 11'(XPOS + CAP_W - 1);
  localparam logic [10:0] Y_LO   = 11'(YPOS);
  localparam logic [10:0] Y_HI   = 11'(YPOS + CAP_H);

  typedef enum logic [1:0] {HIDDEN, ARM, VISIBLE, DISARM} state_e;

  typedef struct packed {
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } pix_t;

  typedef struct packed {
    pix_t pix;
    logic win;
    logic draw;
  } stage_t;

  state_e      state_q, state_d;
  logic [14:0] rowBase_q, rowBase_d;
  logic [14:0] romAddr_q, romAddr_d;
  logic        visible_q, visible_d;
  stage_t      stage1_q, stage1_d, stage2_q;
  pix_t        out_q, out_d;

  logic        frameStart, inRows, inWin;
  logic [10:0] colOffset;
  logic        drawEnNow, drawEnNext;

  assign frameStart = (hcount_in == 11'd0) && (vcount_in == 11'd0);
  assign inRows     = (vcount_in >= Y_LO) && (vcount_in < Y_HI);
  assign inWin      = inRows && (hcount_in >= X_LO) && (hcount_in < X_HI);
  assign colOffset  = hcount_in - X_LO;

  // Row base advances by one caption line on the last window pixel, so no multiplier is needed.
  always_comb begin
    rowBase_d = rowBase_q;
    romAddr_d = 15'd0;
    if (frameStart) begin
      rowBase_d = 15'd0;
    end else if (inRows && (hcount_in == X_LAST)) begin
      rowBase_d = rowBase_q + 15'(CAP_W);
    end
    if (inWin) begin
      romAddr_d = rowBase_q + {4'd0, colOffset};
    end
  end

  // Hide always beats show; arming and disarming only take effect at the next frame start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HIDDEN:  if (show && !hide) state_d = ARM;
      ARM:     if (hide) state_d = HIDDEN;
               else if (frameStart) state_d = VISIBLE;
      VISIBLE: if (hide) state_d = DISARM;
      DISARM:  if (show && !hide) state_d = VISIBLE;
               else if (frameStart) state_d = HIDDEN;
      default: state_d = HIDDEN;
    endcase
  end

`ifdef CAPTION_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [7:0] blinkCnt_q, blinkCnt_d;
  logic       phase_q, phase_d;

  // A fresh show restarts the blink cadence on; re-showing from DISARM keeps the running cadence.
  always_comb begin
    blinkCnt_d = blinkCnt_q;
    phase_d    = phase_q;
    if ((state_q == ARM) && (state_d == VISIBLE)) begin
      blinkCnt_d = 8'd0;
      phase_d    = 1'b1;
    end else if ((state_q == VISIBLE) && frameStart) begin
      if (blinkCnt_q == BLINK_LAST) begin
        blinkCnt_d = 8'd0;
        phase_d    = ~phase_q;
      end else begin
        blinkCnt_d = blinkCnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blinkCnt_q <= 8'd0;
      phase_q    <= 1'b1;
    end else begin
      blinkCnt_q <= blinkCnt_d;
      phase_q    <= phase_d;
    end
  end

  assign drawEnNow  = ((state_q == VISIBLE) || (state_q == DISARM)) && phase_q;
  assign drawEnNext = ((state_d == VISIBLE) || (state_d == DISARM)) && phase_d;
`else
  assign drawEnNow  = (state_q == VISIBLE) || (state_q == DISARM);
  assign drawEnNext = (state_d == VISIBLE) || (state_d == DISARM);
`endif

  always_comb begin
    visible_d = visible_q;
    if (frameStart) begin
      visible_d = drawEnNext;
    end
    stage1_d.pix  = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                      vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in, rgb: rgb_in};
    stage1_d.win  = inWin;
    stage1_d.draw = drawEnNow;
    // ROM data for the stage-2 pixel arrives this cycle, alongside its own window/draw flags.
    out_d = stage2_q.pix;
    if (stage2_q.draw && stage2_q.win && pixel_bit) begin
      out_d.rgb = CAP_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HIDDEN;
      rowBase_q <= 15'd0;
      romAddr_q <= 15'd0;
      visible_q <= 1'b0;
      stage1_q  <= '0;
      stage2_q  <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      rowBase_q <= rowBase_d;
      romAddr_q <= romAddr_d;
      visible_q <= visible_d;
      stage1_q  <= stage1_d;
      stage2_q  <= stage1_q;
      out_q     <= out_d;
    end
  end

  assign rom_address = romAddr_q;
  assign visible     = visible_q;
  assign hcount_out  = out_q.hcount;
  assign hsync_out   = out_q.hsync;
  assign hblnk_out   = out_q.hblnk;
  assign vcount_out  = out_q.vcount;
  assign vsync_out   = out_q.vsync;
  assign vblnk_out   = out_q.vblnk;
  assign rgb_out     = out_q.rgb;

endmodule

// File: tb/tb_caption_overlay_ctl.sv
// Directed bench for caption_overlay_ctl using compressed frames (sparse pixels per caption row).
// Every cycle's outputs are checked against values recorded when that pixel was driven.
module tb_caption_overlay_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic        show = 1'b0, hide = 1'b0;
  logic [14:0] rom_address;
  logic        pixel_bit = 1'b0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        visible;

  always #5 clk = ~clk;

  caption_overlay_ctl #(
    .XPOS(148), .YPOS(268), .CAP_W(344), .CAP_H(64), .CAP_COLOR(12'hF00)
`ifdef CAPTION_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .show(show), .hide(hide),
    .rom_address(rom_address), .pixel_bit(pixel_bit),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .visible(visible)
  );

  // Caption ROM stand-in: odd addresses hold a lit pixel, one clock of read latency.
  always @(posedge clk) pixel_bit <= rom_address[0];

  typedef struct {
    logic [10:0] h, v;
    logic        hs, hb, vs, vb;
    logic [11:0] rgb;
    bit          rst, on, addrChk;
  } rec_t;

  rec_t hist [8];
  int   n = 0;
  int   checks = 0;
  int   errors = 0;
  bit   capOn = 1'b0;
  bit   addrChk = 1'b1;
  bit   rgbIdle = 1'b0;
  int   hList [10] = '{100, 147, 148, 149, 150, 300, 490, 491, 492, 500};
  bit   pat [6];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit inWin(input logic [10:0] h, input logic [10:0] v);
    return (h >= 11'd148) && (h < 11'd492) && (v >= 11'd268) && (v < 11'd332);
  endfunction

  function automatic int expAddr(input logic [10:0] h, input logic [10:0] v);
    if (!inWin(h, v)) return 0;
    return (int'(v) - 268) * 344 + (int'(h) - 148);
  endfunction

  // One pixel per clock: check what the DUT shows for earlier pixels, then drive the next one.
  task automatic applyStimulus(input logic [10:0] h, input logic [10:0] v,
                               input bit doRst, input bit doShow, input bit doHide);
    rec_t        r1, r2, r3;
    bit          z;
    int          a;
    logic [11:0] eRgb;
    logic [25:0] eTim;
    @(posedge clk);
    #1;
    if (n >= 3) begin
      r1 = hist[(n - 1) & 7];
      r2 = hist[(n - 2) & 7];
      r3 = hist[(n - 3) & 7];
      z  = r1.rst || r2.rst || r3.rst;
      a  = expAddr(r3.h, r3.v);
      eRgb = (r3.on && inWin(r3.h, r3.v) && a[0]) ? 12'hF00 : r3.rgb;
      eTim = {r3.h, r3.hs, r3.hb, r3.v, r3.vs, r3.vb};
      checkOutput("rgb", 32'(rgb_out), z ? 32'd0 : 32'(eRgb));
      checkOutput("timing", 32'({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}),
                  z ? 32'd0 : 32'(eTim));
      checkOutput("visible", 32'(visible), r1.rst ? 32'd0 : 32'(r1.on));
      if (r1.rst) checkOutput("romaddr", 32'(rom_address), 32'd0);
      else if (r1.addrChk) checkOutput("romaddr", 32'(rom_address), 32'(expAddr(r1.h, r1.v)));
    end
    hcount_in = h;
    vcount_in = v;
    hsync_in  = h[1];
    hblnk_in  = h[2];
    vsync_in  = v[1];
    vblnk_in  = v[2];
    rgb_in    = rgbIdle ? 12'h0A0 : {h[5:0], v[5:0]};
    rst       = doRst;
    show      = doShow;
    hide      = doHide;
    hist[n & 7] = '{h: h, v: v, hs: h[1], hb: h[2], vs: v[1], vb: v[2], rgb: rgb_in,
                    rst: doRst, on: capOn, addrChk: addrChk};
    n++;
  endtask

  // A compressed frame: the frame-start pixel, then a sparse set of columns on rows 266..333.
  task automatic runFrame(input bit on, input int evRow, input bit evShow, input bit evHide,
                          input bit evRst);
    bit ev;
    capOn   = on;
    addrChk = 1'b1;
    applyStimulus(11'd0, 11'd0, 1'b0, 1'b0, 1'b0);
    for (int v = 266; v <= 333; v++) begin
      for (int i = 0; i < 10; i++) begin
        ev = (v == evRow) && (hList[i] == 300);
        applyStimulus(11'(hList[i]), 11'(v), ev && evRst, ev && evShow, ev && evHide);
        if (ev && evRst) begin
          capOn   = 1'b0;
          addrChk = 1'b0;
        end
      end
    end
  endtask

  initial begin
`ifdef CAPTION_BLINK_EN
    pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int i = 0; i < 4; i++) applyStimulus(11'd0, 11'd5, 1'b1, 1'b0, 1'b0);

    $display("[TB] idle frame, constant background");
    rgbIdle = 1'b1;
    runFrame(1'b0, -1, 1'b0, 1'b0, 1'b0);
    rgbIdle = 1'b0;

    $display("[TB] show mid-frame, caption from next frame on");
    runFrame(1'b0, 300, 1'b1, 1'b0, 1'b0);
    for (int f = 0; f < 6; f++) begin
      runFrame(pat[f], (f == 5) ? 300 : -1, 1'b0, f == 5, 1'b0);
    end

    $display("[TB] hidden frame with simultaneous show and hide");
    runFrame(1'b0, 300, 1'b1, 1'b1, 1'b0);

    $display("[TB] re-arm, then reset inside the window");
    runFrame(1'b0, 300, 1'b1, 1'b0, 1'b0);
    runFrame(1'b1, 280, 1'b0, 1'b0, 1'b1);
    runFrame(1'b0, -1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) applyStimulus(11'd600, 11'd10, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
